// File: rtl/step_sequencer.sv
// Step/run advance controller for a 6-state light FSM: free-running prescaled
// TH strobes, debounced single-step button, wrap counting and illegal-state flag.
module step_sequencer #(
    parameter int unsigned DIV_BASE = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic       i_step_btn,
    input  logic [1:0] i_div_sel,
    input  logic [2:0] i_state_in,
    output logic       o_th,
    output logic       o_wrap,
    output logic [3:0] o_wrap_cnt,
    output logic       o_busy,
    output logic       o_err
);

    localparam int unsigned PW = $clog2(8 * DIV_BASE);
    localparam logic [2:0] LAST_STATE = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_STEP,
        S_WAIT_REL
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   r_period_m1;
    logic            r_th;
    logic            r_busy;
    logic            r_wrap;
    logic [3:0]      r_wrap_cnt;
    logic            r_err;

    logic            r_btn_meta;
    logic            r_btn_sync;
    logic            r_btn_prev;
    logic [1:0]      r_fill;
    logic            r_armed;

    logic [PW-1:0]   w_period_m1;
    logic            w_step_req;
    logic            w_wrap_hit;
    logic            w_illegal;

    // Interval length minus one for the currently selected divider
    assign w_period_m1 = PW'((DIV_BASE << i_div_sel) - 32'd1);

    // Button synchronizer; r_fill marks when r_btn_sync holds a real sample so a
    // button held through reset never looks like a fresh press.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_prev <= 1'b0;
            r_fill     <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_btn_meta <= i_step_btn;
            r_btn_sync <= r_btn_meta;
            r_btn_prev <= r_btn_sync;
            r_fill     <= {r_fill[0], 1'b1};
            if (r_fill[1] && !r_btn_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_step_req = r_armed & r_btn_sync & ~r_btn_prev;

    // Controller FSM with registered TH and BUSY
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_period_m1 <= PW'(DIV_BASE - 32'd1);
            r_th        <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_th <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    if (i_run) begin
                        r_state     <= S_RUNNING;
                        r_period_m1 <= w_period_m1;
                        r_busy      <= 1'b1;
                    end else if (w_step_req) begin
                        r_state <= S_STEP;
                        r_th    <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUNNING: begin
                    if (!i_run) begin
                        r_state <= S_IDLE;
                        r_presc <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_presc == r_period_m1) begin
                        r_presc     <= '0;
                        r_th        <= 1'b1;
                        r_period_m1 <= w_period_m1;
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                S_STEP: begin
                    r_state <= S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!r_btn_sync) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_presc <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_wrap_hit = r_th && (i_state_in == LAST_STATE);
    assign w_illegal  = i_state_in[2] & i_state_in[1];

    // Wrap detection and sticky illegal-state flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wrap     <= 1'b0;
            r_wrap_cnt <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_wrap <= w_wrap_hit;
            if (w_wrap_hit) begin
                r_wrap_cnt <= r_wrap_cnt + 4'd1;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_th       = r_th;
    assign o_busy     = r_busy;
    assign o_wrap     = r_wrap;
    assign o_wrap_cnt = r_wrap_cnt;
    assign o_err      = r_err;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer with DIV_BASE=4 and a 0..5
// light-FSM model fed back on STATE_IN.
module tb_step_sequencer;

    localparam int unsigned DIV_BASE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       btn = 1'b0;
    logic [1:0] div_sel = 2'b00;
    logic [2:0] state_in;
    logic       th;
    logic       wrap;
    logic [3:0] wrap_cnt;
    logic       busy;
    logic       err;

    logic [2:0] light;
    logic       force_ill = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    step_sequencer #(.DIV_BASE(DIV_BASE)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_run      (run),
        .i_step_btn (btn),
        .i_div_sel  (div_sel),
        .i_state_in (state_in),
        .o_th       (th),
        .o_wrap     (wrap),
        .o_wrap_cnt (wrap_cnt),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Light FSM model: advances 0..5 on each TH
    always @(posedge clk or posedge reset) begin
        if (reset) light <= 3'd0;
        else if (th) light <= (light == 3'd5) ? 3'd0 : light + 3'd1;
    end

    assign state_in = force_ill ? 3'b110 : light;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_th(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (th !== 1'b1 && n < bound);
        if (th !== 1'b1) n = -1;
    endtask

    task automatic do_reset;
        run = 1'b0; btn = 1'b0; div_sel = 2'b00; force_ill = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        tests_run++;
        if (th !== 1'b0) begin tests_failed++; $display("FAIL reset_th: got %b expected 0", th); end
        tests_run++;
        if (wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        tests_run++;
        if (wrap_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_wrap_cnt: got %b expected 0000", wrap_cnt); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_run;
        int th_cnt = 0;
        int bad_th = 0;
        int bad_busy = 0;
        logic exp_th;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            tick();
            exp_th = (c > 1) && ((c - 1) % 4 == 0);
            if (th === 1'b1) th_cnt++;
            if (th !== exp_th) bad_th++;
            if (busy !== 1'b1) bad_busy++;
        end
        tests_run++;
        if (th_cnt != 10) begin tests_failed++; $display("FAIL run_th_count: got %0d expected 10", th_cnt); end
        tests_run++;
        if (bad_th != 0) begin tests_failed++; $display("FAIL run_th_timing: got %0d wrong cycles expected 0", bad_th); end
        tests_run++;
        if (bad_busy != 0) begin tests_failed++; $display("FAIL run_busy: got %0d low cycles expected 0", bad_busy); end
        run = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_busy: got %b expected 0", busy); end
        th_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (th === 1'b1) th_cnt++;
        end
        tests_run++;
        if (th_cnt != 0) begin tests_failed++; $display("FAIL stop_th: got %0d pulses expected 0", th_cnt); end
    endtask

    task automatic test_step;
        int cnt = 0;
        int first = -1;
        do_reset();
        btn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (th === 1'b1) begin
                cnt++;
                if (first < 0) first = c;
            end
        end
        tests_run++;
        if (cnt != 1) begin tests_failed++; $display("FAIL step_count: got %0d expected 1", cnt); end
        tests_run++;
        if (first != 3) begin tests_failed++; $display("FAIL step_latency: got %0d expected 3", first); end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL step_busy_held: got %b expected 1", busy); end
        btn = 1'b0;
        tick(); tick();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL step_busy_sync: got %b expected 1", busy); end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL step_busy_drop: got %b expected 0", busy); end
        tick(); tick();
        btn = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (th === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt != 1) begin tests_failed++; $display("FAIL step_again: got %0d expected 1", cnt); end
        btn = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_btn_held_reset;
        int cnt = 0;
        run = 1'b0;
        btn = 1'b1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (th === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt != 0) begin tests_failed++; $display("FAIL held_reset_th: got %0d expected 0", cnt); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL held_reset_busy: got %b expected 0", busy); end
        btn = 1'b0;
        tick(); tick(); tick();
        btn = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (th === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt != 1) begin tests_failed++; $display("FAIL held_repress: got %0d expected 1", cnt); end
        btn = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_wrap;
        int n_th = 0;
        int n_wrap = 0;
        int bad = 0;
        int c = 0;
        logic prev_th = 1'b0;
        do_reset();
        run = 1'b1;
        while (n_th < 12 && c < 200) begin
            tick();
            c++;
            if (th === 1'b1 && prev_th === 1'b1) bad++;
            if (wrap === 1'b1 && prev_th !== 1'b1) bad++;
            if (th === 1'b1) n_th++;
            if (wrap === 1'b1) n_wrap++;
            prev_th = th;
        end
        tick();
        if (wrap === 1'b1) n_wrap++;
        if (wrap === 1'b1 && prev_th !== 1'b1) bad++;
        run = 1'b0;
        tests_run++;
        if (n_th != 12) begin tests_failed++; $display("FAIL wrap_th_count: got %0d expected 12", n_th); end
        tests_run++;
        if (n_wrap != 2) begin tests_failed++; $display("FAIL wrap_pulses: got %0d expected 2", n_wrap); end
        tests_run++;
        if (wrap_cnt !== 4'b0010) begin tests_failed++; $display("FAIL wrap_cnt: got %b expected 0010", wrap_cnt); end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL wrap_timing: got %0d bad cycles expected 0", bad); end
        tests_run++;
        if (light !== 3'd0) begin tests_failed++; $display("FAIL wrap_light: got %0d expected 0", light); end
    endtask

    task automatic test_wrap_rollover;
        int n_wrap = 0;
        int c = 0;
        logic [3:0] cnt16 = 4'hF;
        do_reset();
        run = 1'b1;
        while (n_wrap < 17 && c < 1000) begin
            tick();
            c++;
            if (wrap === 1'b1) begin
                n_wrap++;
                if (n_wrap == 16) cnt16 = wrap_cnt;
            end
        end
        run = 1'b0;
        tests_run++;
        if (n_wrap != 17) begin tests_failed++; $display("FAIL rollover_pulses: got %0d expected 17", n_wrap); end
        tests_run++;
        if (cnt16 !== 4'd0) begin tests_failed++; $display("FAIL rollover_16: got %b expected 0000", cnt16); end
        tests_run++;
        if (wrap_cnt !== 4'd1) begin tests_failed++; $display("FAIL rollover_17: got %b expected 0001", wrap_cnt); end
    endtask

    task automatic test_div_change;
        int n;
        do_reset();
        run = 1'b1;
        wait_th(20, n);
        tests_run++;
        if (n != 5) begin tests_failed++; $display("FAIL div_first: got %0d expected 5", n); end
        tick();
        div_sel = 2'b11;
        wait_th(20, n);
        tests_run++;
        if (n != 3) begin tests_failed++; $display("FAIL div_current: got %0d expected 3", n); end
        wait_th(60, n);
        tests_run++;
        if (n != 32) begin tests_failed++; $display("FAIL div_next1: got %0d expected 32", n); end
        wait_th(60, n);
        tests_run++;
        if (n != 32) begin tests_failed++; $display("FAIL div_next2: got %0d expected 32", n); end
        run = 1'b0;
        div_sel = 2'b00;
        tick();
    endtask

    task automatic test_err;
        int n;
        do_reset();
        run = 1'b1;
        wait_th(20, n);
        tick();
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL err_before: got %b expected 0", err); end
        force_ill = 1'b1;
        tick();
        force_ill = 1'b0;
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b expected 1", err); end
        wait_th(20, n);
        tests_run++;
        if (n != 2) begin tests_failed++; $display("FAIL err_th_gap1: got %0d expected 2", n); end
        wait_th(20, n);
        tests_run++;
        if (n != 4) begin tests_failed++; $display("FAIL err_th_gap2: got %0d expected 4", n); end
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err); end
        do_reset();
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got %b expected 0", err); end
    endtask

    task automatic test_reset_mid;
        int n;
        int cnt = 0;
        do_reset();
        run = 1'b1;
        wait_th(20, n);
        tick(); tick();
        reset = 1'b1;
        #1;
        tests_run++;
        if ({th, wrap, busy, err, wrap_cnt} !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %b expected 00000000", {th, wrap, busy, err, wrap_cnt});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (th === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt != 0) begin tests_failed++; $display("FAIL midreset_th: got %0d expected 0", cnt); end
        reset = 1'b0;
        wait_th(20, n);
        tests_run++;
        if (n != 5) begin tests_failed++; $display("FAIL midreset_restart: got %0d expected 5", n); end
        run = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_run();
        test_step();
        test_btn_held_reset();
        test_wrap();
        test_wrap_rollover();
        test_div_change();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter DIV_BASE, default 16: base advance period in CLK cycles; legal range 2..4096.
REQ-002 CLK  input  1  single clock; all flops on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 RUN  input  1  level, synchronous to CLK; 1 = free-running advance, 0 = stop.
REQ-005 STEP_BTN  input  1  asynchronous push-button; each press requests one single advance.
REQ-006 DIV_SEL  input  2  period select: 00 = DIV_BASE, 01 = 2*DIV_BASE, 10 = 4*DIV_BASE, 11 = 8*DIV_BASE cycles.
REQ-007 STATE_IN  input  3  feedback of the 6-state light FSM state bits {LE2,LE1,LE0}; legal 000..101.
REQ-008 TH  output  1  advance strobe to the light FSM; registered, one-cycle pulse.
REQ-009 WRAP  output  1  registered one-cycle pulse: FSM completed a full cycle 101 -> 000.
REQ-010 WRAP_CNT  output  4  count of WRAP pulses, modulo 16.
REQ-011 BUSY  output  1  1 while controller is in RUNNING or STEP or WAIT_REL.
REQ-012 ERR  output  1  sticky flag: illegal STATE_IN observed.

Function
REQ-013 STEP_BTN shall pass through a 2-flop synchronizer; a rising edge of the synchronized signal shall form a one-cycle internal step request.
REQ-014 Controller FSM states shall be IDLE, RUNNING, STEP, WAIT_REL.
REQ-015 IDLE: RUN=1 -> RUNNING (prescaler cleared to 0); else step request -> STEP; else stay; RUN has priority over a simultaneous step request.
REQ-016 RUNNING: prescaler increments each cycle; at prescaler == PERIOD-1, TH asserts the next cycle and prescaler clears, giving TH pulses exactly PERIOD cycles apart, first pulse PERIOD cycles after RUNNING entry.
REQ-017 RUNNING: RUN=0 -> IDLE with prescaler cleared; no TH is issued on or after the cycle RUN=0 is sampled.
REQ-018 Step requests arriving in RUNNING, STEP or WAIT_REL shall be discarded.
REQ-019 STEP: TH high for exactly one cycle, then -> WAIT_REL.
REQ-020 WAIT_REL: stay until synchronized STEP_BTN = 0, then -> IDLE; a held button yields exactly one TH.
REQ-021 PERIOD shall be latched from DIV_SEL on RUNNING entry and on every TH in RUNNING; DIV_SEL changes mid-interval take effect at the next interval.
REQ-022 Prescaler width shall hold 8*DIV_BASE-1 without overflow.
REQ-023 WRAP shall assert the cycle after a TH pulse during which STATE_IN == 101; WRAP_CNT shall increment with WRAP, 1111 -> 0000.
REQ-024 TH shall never be high in two consecutive cycles.
REQ-025 ERR shall set the cycle after STATE_IN is 110 or 111 and hold until RESET; TH generation continues unaffected.

Reset
REQ-026 RESET=1 shall immediately force controller to IDLE, prescaler 0, synchronizer flops 0, TH=0, WRAP=0, WRAP_CNT=0000, BUSY=0, ERR=0.
REQ-027 RESET asserted mid-interval or mid-step shall abort with no TH pulse; after deassertion operation restarts from IDLE.
REQ-028 A STEP_BTN held high through RESET release shall not generate a step (synchronizer reset to 0 sees no edge until re-press... edge detect shall require a 0 sample after reset).

Verification
REQ-029 DIV_BASE=4, DIV_SEL=00, RUN=1 for 40 cycles -> TH pulses every 4 cycles, first 4 cycles after RUNNING entry, 10 pulses total, BUSY=1 throughout.
REQ-030 RUN=0, STEP_BTN high 20 cycles -> exactly one TH within 4 cycles of press; BUSY drops 1 cycle after release is synchronized.
REQ-031 STATE_IN modelled by a 0..5 counter advanced by TH, 12 TH pulses -> WRAP pulses twice, WRAP_CNT=0010.
REQ-032 DIV_SEL 00 -> 11 mid-interval with DIV_BASE=4 -> current interval stays 4 cycles, following intervals 32 cycles.
REQ-033 STATE_IN=110 for one cycle -> ERR=1 next cycle and stays 1 until RESET; TH spacing unchanged.
REQ-034 RESET pulsed 2 cycles before a due TH in RUNNING -> no TH, all outputs 0; with RUN=1 after release, first TH PERIOD cycles after RUNNING re-entry.
